decode_stage: RTL and testbench
===============================

// Module: decode_stage
// PURPOSE
//  RV32I decode stage: decodes the IF/ID instruction, drives register-file read addresses, selects operands and captures the ID/EX register.
//  Sits between fetch and execute; register_file sits beside it and is read combinationally.
//  Owns RAW hazard detection, the WB->ID bypass, load-use stalls and pipeline flush.
// PARAMETERS
//  XLEN        32  datapath width
//  REG_ADDR_W  5   register address width
// PORTS
//  clock           in   1      pipeline clock, rising edge
//  reset_n         in   1      asynchronous, active-low reset
//  if_valid        in   1      IF/ID holds an instruction
//  if_instr        in   32     instruction word
//  if_pc           in   XLEN   instruction PC
//  id_ready        out  1      decode accepts if_instr this cycle
//  rf_read1        out  5      rs1 address to register file
//  rf_read2        out  5      rs2 address to register file
//  rf_data1        in   XLEN   register file data for rs1
//  rf_data2        in   XLEN   register file data for rs2
//  exmem_regwrite  in   1      EX/MEM instruction writes rd
//  exmem_memread   in   1      EX/MEM instruction is a load
//  exmem_rd        in   5      EX/MEM destination register
//  exmem_data      in   XLEN   EX/MEM ALU result
//  wb_regwrite     in   1      WB write enable; same signal as the register-file write port
//  wb_rd           in   5      WB destination register
//  wb_data         in   XLEN   WB write data
//  ex_stall        in   1      execute cannot accept; hold ID/EX
//  flush           in   1      redirect (branch/jump taken); kill the decode and ID/EX contents
//  ex_valid        out  1      ID/EX holds a valid instruction
//  ex_pc           out  XLEN   ID/EX PC
//  ex_op1          out  XLEN   ID/EX rs1 operand value
//  ex_op2          out  XLEN   ID/EX rs2 operand value
//  ex_imm          out  XLEN   ID/EX sign-extended immediate
//  ex_rd           out  5      ID/EX destination register
//  ex_opcode       out  7      ID/EX opcode field
//  ex_funct3       out  3      ID/EX funct3 field
//  ex_funct7b5     out  1      ID/EX bit 30 of the instruction
//  ex_regwrite     out  1      ID/EX instruction writes rd
//  ex_memread      out  1      ID/EX instruction is a load
//  ex_memwrite     out  1      ID/EX instruction is a store
//  ex_illegal      out  1      ID/EX opcode is unsupported
// BEHAVIOUR
//  Reset: every ex_* output is 0; id_ready is 1 (combinational output).
//  Register-file reads: rf_read1 = instr[19:15] and rf_read2 = instr[24:20], driven combinationally.
//  Latency: an instruction reaches ID/EX one cycle after it is accepted (if_valid && id_ready).
//  Register usage:
//   - rs1 is used by every opcode except LUI, AUIPC and JAL.
//   - rs2 is used only by OP, STORE and BRANCH.
//   - A register match counts only when the register is used and its address is non-zero.
//  Operand selection, highest priority first:
//   - x0 reads as 0.
//   - EX/MEM forward, only when FORWARDING_EN is defined.
//   - WB bypass, always present; the register file writes at the clock edge, so a same-cycle read would otherwise return the old value.
//   - rf_data.
//  Hazard stall (hz): the stage holds the instruction in decode when any of these is true:
//   (a) ID/EX is valid, has regwrite, and its rd matches a used rs.
//   (b) EX/MEM regwrite, exmem_rd matches a used rs, and exmem_memread is set (load-use).
//  On hz with !ex_stall: id_ready=0, and a bubble is written into ID/EX (ex_valid=0, all control outputs 0).
//  ex_stall: ID/EX holds its contents and id_ready=0. When ex_stall and hz occur together, ex_stall wins (hold).
//  flush has top priority:
//   - ID/EX is cleared on the next edge.
//   - id_ready=1, and the incoming instruction is accepted and dropped.
//  Unknown opcode: ex_valid=1, ex_illegal=1, regwrite/memread/memwrite all 0.
//  Immediates: I, S, B, U and J formats, sign-extended to XLEN.
//  Asserting reset mid-stall clears ID/EX immediately; no state survives reset.
// CONFIGURATION
//  FORWARDING_EN defined:
//   - A non-load EX/MEM producer is forwarded from exmem_data with no stall.
//   - A load in EX/MEM stalls, per rule (b).
//  FORWARDING_EN undefined:
//   - Any EX/MEM regwrite match stalls until the producer reaches WB, where the WB bypass supplies the value.
// STRUCTURE
//  riscv_pkg: opcode localparams (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC), the imm-format encoding, XLEN.
//  Sub-module imm_gen: combinational immediate generator (instr -> format -> imm).
// TESTING
//  1. addi x1,x0,5 -> ex_valid=1, ex_imm=5, ex_op1=0, ex_rd=1, ex_regwrite=1.
//  2. WB writes x3=0xDEAD while decode reads add x4,x3,x3 -> ex_op1 = ex_op2 = 0xDEAD.
//  3. lw x2,0(x1), then add x5,x2,x2:
//   - FORWARDING_EN defined: exactly 2 bubbles, then ex_op1 = the load data.
//   - FORWARDING_EN undefined: also 2 bubbles.
//  4. add x6,.. then sub x7,x6,x6:
//   - FORWARDING_EN defined: 1 bubble, then ex_op1 = exmem_data.
//   - FORWARDING_EN undefined: 2 bubbles.
//  5. flush and ex_stall asserted together -> ex_valid=0 next cycle, id_ready=1.
//  6. reset_n low mid-stall -> all ex_* = 0 asynchronously; the first instruction after release decodes correctly.

Source files
------------

// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
//   Shared RV32I definitions for the decode stage:
//     - datapath width and register address width
//     - base opcode encodings used by decode
//     - immediate format encoding (imm_fmt_e)
//     - decode_opcode(): per-opcode control summary (dec_ctrl_t)
// -----------------------------------------------------------------------------
package riscv_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_e;

    typedef struct packed {
        logic     regwrite;
        logic     memread;
        logic     memwrite;
        logic     illegal;
        logic     use_rs1;
        logic     use_rs2;
        imm_fmt_e imm_fmt;
    } dec_ctrl_t;

    // Control summary of one opcode. Unknown opcodes are flagged illegal and
    // keep every side-effecting control low; they still count as rs1 users.
    function automatic dec_ctrl_t decode_opcode(input logic [6:0] opcode);
        dec_ctrl_t c;
        c         = '0;
        c.use_rs1 = 1'b1;
        case (opcode)
            OPC_OP: begin
                c.regwrite = 1'b1;
                c.use_rs2  = 1'b1;
            end
            OPC_OP_IMM: begin
                c.regwrite = 1'b1;
                c.imm_fmt  = IMM_I;
            end
            OPC_LOAD: begin
                c.regwrite = 1'b1;
                c.memread  = 1'b1;
                c.imm_fmt  = IMM_I;
            end
            OPC_STORE: begin
                c.memwrite = 1'b1;
                c.use_rs2  = 1'b1;
                c.imm_fmt  = IMM_S;
            end
            OPC_BRANCH: begin
                c.use_rs2  = 1'b1;
                c.imm_fmt  = IMM_B;
            end
            OPC_JAL: begin
                c.regwrite = 1'b1;
                c.use_rs1  = 1'b0;
                c.imm_fmt  = IMM_J;
            end
            OPC_JALR: begin
                c.regwrite = 1'b1;
                c.imm_fmt  = IMM_I;
            end
            OPC_LUI, OPC_AUIPC: begin
                c.regwrite = 1'b1;
                c.use_rs1  = 1'b0;
                c.imm_fmt  = IMM_U;
            end
            default: begin
                c.illegal  = 1'b1;
            end
        endcase
        return c;
    endfunction

endpackage

// File: rtl/imm_gen.sv
// -----------------------------------------------------------------------------
// imm_gen
//   Combinational RV32I immediate generator. Rebuilds the I/S/B/U/J immediate
//   from the instruction bits and sign-extends it to XLEN. IMM_NONE gives 0.
// Ports
//   instr_i  in   [31:7]  instruction word above the opcode field
//   fmt_i    in   enum    immediate format selected by decode
//   imm_o    out  XLEN    sign-extended immediate
// -----------------------------------------------------------------------------
module imm_gen
    import riscv_pkg::*;
#(
    parameter int XLEN = riscv_pkg::XLEN
) (
    input  logic [31:7]     instr_i,
    input  imm_fmt_e        fmt_i,
    output logic [XLEN-1:0] imm_o
);

    logic [31:0] imm32;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so
        // no path through the case can leave it unassigned and infer a latch.
        imm32 = '0;
        case (fmt_i)
            IMM_I: imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
            IMM_S: imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            IMM_B: imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                            instr_i[30:25], instr_i[11:8], 1'b0};
            IMM_U: imm32 = {instr_i[31:12], 12'b0};
            IMM_J: imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                            instr_i[20], instr_i[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    assign imm_o = XLEN'(signed'(imm32));

endmodule

// File: rtl/decode_stage.sv
// -----------------------------------------------------------------------------
// decode_stage
//   RV32I decode stage. Decodes the IF/ID instruction, drives the register
//   file read addresses, selects operands (x0 / EX-MEM forward / WB bypass /
//   register file), detects RAW and load-use hazards, and captures ID/EX.
//
// Configuration
//   FORWARDING_EN  defined: non-load EX/MEM producers are forwarded from
//                  exmem_data; only a load in EX/MEM stalls.
//                  undefined: any EX/MEM producer match stalls until it
//                  reaches WB, where the WB bypass supplies the value.
//
// Ports
//   clock, reset_n                      clock, async active-low reset
//   if_valid, if_instr, if_pc           IF/ID contents
//   id_ready                            decode accepts if_instr this cycle
//   rf_read1/2, rf_data1/2              combinational register-file read
//   exmem_regwrite/memread/rd/data      EX/MEM producer information
//   wb_regwrite/rd/data                 WB write port (same as register file)
//   ex_stall                            execute cannot accept; hold ID/EX
//   flush                               redirect; kill decode and ID/EX
//   ex_*                                registered ID/EX contents
// -----------------------------------------------------------------------------
module decode_stage
    import riscv_pkg::*;
#(
    parameter int XLEN       = riscv_pkg::XLEN,
    parameter int REG_ADDR_W = riscv_pkg::REG_ADDR_W
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  if_valid,
    input  logic [31:0]           if_instr,
    input  logic [XLEN-1:0]       if_pc,
    output logic                  id_ready,
    output logic [REG_ADDR_W-1:0] rf_read1,
    output logic [REG_ADDR_W-1:0] rf_read2,
    input  logic [XLEN-1:0]       rf_data1,
    input  logic [XLEN-1:0]       rf_data2,
    input  logic                  exmem_regwrite,
    input  logic                  exmem_memread,
    input  logic [REG_ADDR_W-1:0] exmem_rd,
    input  logic [XLEN-1:0]       exmem_data,
    input  logic                  wb_regwrite,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic [XLEN-1:0]       wb_data,
    input  logic                  ex_stall,
    input  logic                  flush,
    output logic                  ex_valid,
    output logic [XLEN-1:0]       ex_pc,
    output logic [XLEN-1:0]       ex_op1,
    output logic [XLEN-1:0]       ex_op2,
    output logic [XLEN-1:0]       ex_imm,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic [6:0]            ex_opcode,
    output logic [2:0]            ex_funct3,
    output logic                  ex_funct7b5,
    output logic                  ex_regwrite,
    output logic                  ex_memread,
    output logic                  ex_memwrite,
    output logic                  ex_illegal
);

    typedef struct packed {
        logic                  valid;
        logic [XLEN-1:0]       pc;
        logic [XLEN-1:0]       op1;
        logic [XLEN-1:0]       op2;
        logic [XLEN-1:0]       imm;
        logic [REG_ADDR_W-1:0] rd;
        logic [6:0]            opcode;
        logic [2:0]            funct3;
        logic                  funct7b5;
        logic                  regwrite;
        logic                  memread;
        logic                  memwrite;
        logic                  illegal;
    } idex_t;

    idex_t                 idex_q, idex_d, dec;
    dec_ctrl_t             ctrl;
    logic [REG_ADDR_W-1:0] rs1, rs2;
    logic                  use_rs1, use_rs2;
    logic [XLEN-1:0]       imm, op1, op2;
    logic                  idex_hit, exmem_hit, exmem_stall, hz;

    // ---------------------------------------------------------------- decode
    assign rs1      = if_instr[19:15];
    assign rs2      = if_instr[24:20];
    assign rf_read1 = rs1;
    assign rf_read2 = rs2;
    assign ctrl     = decode_opcode(if_instr[6:0]);

    // x0 never creates a dependency.
    assign use_rs1 = ctrl.use_rs1 && (rs1 != '0);
    assign use_rs2 = ctrl.use_rs2 && (rs2 != '0);

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr_i (if_instr[31:7]),
        .fmt_i   (ctrl.imm_fmt),
        .imm_o   (imm)
    );

    // ------------------------------------------------------ operand selection
    // Later assignments override earlier ones, so the order below is lowest
    // priority first: rf_data, WB bypass, EX/MEM forward, x0.
    always_comb begin
        op1 = rf_data1;
        op2 = rf_data2;
        // The register file writes at the edge, so its read still shows the
        // old value while the WB write is in flight.
        if (wb_regwrite && (wb_rd == rs1)) op1 = wb_data;
        if (wb_regwrite && (wb_rd == rs2)) op2 = wb_data;
`ifdef FORWARDING_EN
        // Load data is not available in EX/MEM; those cases stall instead.
        if (exmem_regwrite && !exmem_memread && (exmem_rd == rs1)) op1 = exmem_data;
        if (exmem_regwrite && !exmem_memread && (exmem_rd == rs2)) op2 = exmem_data;
`endif
        if (rs1 == '0) op1 = '0;
        if (rs2 == '0) op2 = '0;
    end

    // ------------------------------------------------------ hazard detection
    assign idex_hit  = idex_q.valid && idex_q.regwrite &&
                       ((use_rs1 && (idex_q.rd == rs1)) || (use_rs2 && (idex_q.rd == rs2)));
    assign exmem_hit = exmem_regwrite &&
                       ((use_rs1 && (exmem_rd == rs1)) || (use_rs2 && (exmem_rd == rs2)));

`ifdef FORWARDING_EN
    assign exmem_stall = exmem_hit && exmem_memread;
`else
    assign exmem_stall = exmem_hit;

    // Without forwarding the EX/MEM value and load flag play no part.
    logic unused_exmem_inputs;
    assign unused_exmem_inputs = ^{exmem_memread, exmem_data};
`endif

    assign hz       = if_valid && (idex_hit || exmem_stall);
    // A flush drops whatever is offered, so decode is always ready then.
    assign id_ready = flush || !(ex_stall || hz);

    // ------------------------------------------------------- ID/EX next state
    always_comb begin
        dec          = '0;
        dec.valid    = 1'b1;
        dec.pc       = if_pc;
        dec.op1      = op1;
        dec.op2      = op2;
        dec.imm      = imm;
        dec.rd       = if_instr[11:7];
        dec.opcode   = if_instr[6:0];
        dec.funct3   = if_instr[14:12];
        dec.funct7b5 = if_instr[30];
        dec.regwrite = ctrl.regwrite;
        dec.memread  = ctrl.memread;
        dec.memwrite = ctrl.memwrite;
        dec.illegal  = ctrl.illegal;
    end

    // Priority: flush clears, ex_stall holds, hazard or empty IF/ID inserts a
    // bubble, otherwise the decoded instruction advances.
    always_comb begin
        idex_d = idex_q;
        if (flush) begin
            idex_d = '0;
        end else if (!ex_stall) begin
            idex_d = (if_valid && !hz) ? dec : '0;
        end
    end

    // NOTE: ID/EX is pipeline control state, so it is cleared by the async
    // reset; a stale ex_valid would launch a phantom instruction.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            idex_q <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values.
            idex_q <= idex_d;
        end
    end

    assign ex_valid    = idex_q.valid;
    assign ex_pc       = idex_q.pc;
    assign ex_op1      = idex_q.op1;
    assign ex_op2      = idex_q.op2;
    assign ex_imm      = idex_q.imm;
    assign ex_rd       = idex_q.rd;
    assign ex_opcode   = idex_q.opcode;
    assign ex_funct3   = idex_q.funct3;
    assign ex_funct7b5 = idex_q.funct7b5;
    assign ex_regwrite = idex_q.regwrite;
    assign ex_memread  = idex_q.memread;
    assign ex_memwrite = idex_q.memwrite;
    assign ex_illegal  = idex_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// -----------------------------------------------------------------------------
// tb_decode_stage
//   Directed scenarios for the decode stage followed by randomized traffic
//   compared against a behavioural model of the ID/EX register.
// -----------------------------------------------------------------------------
module tb_decode_stage;
    import riscv_pkg::*;

`ifdef FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        if_valid, id_ready;
    logic [31:0] if_instr, if_pc;
    logic [4:0]  rf_read1, rf_read2;
    logic [31:0] rf_data1, rf_data2;
    logic        exmem_regwrite, exmem_memread;
    logic [4:0]  exmem_rd;
    logic [31:0] exmem_data;
    logic        wb_regwrite;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        ex_stall, flush;
    logic        ex_valid, ex_funct7b5, ex_regwrite, ex_memread, ex_memwrite, ex_illegal;
    logic [31:0] ex_pc, ex_op1, ex_op2, ex_imm;
    logic [4:0]  ex_rd;
    logic [6:0]  ex_opcode;
    logic [2:0]  ex_funct3;

    always #5 clock = ~clock;

    decode_stage dut (
        .clock(clock), .reset_n(reset_n),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .id_ready(id_ready),
        .rf_read1(rf_read1), .rf_read2(rf_read2), .rf_data1(rf_data1), .rf_data2(rf_data2),
        .exmem_regwrite(exmem_regwrite), .exmem_memread(exmem_memread),
        .exmem_rd(exmem_rd), .exmem_data(exmem_data),
        .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
        .ex_stall(ex_stall), .flush(flush),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_op1(ex_op1), .ex_op2(ex_op2),
        .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_opcode(ex_opcode), .ex_funct3(ex_funct3),
        .ex_funct7b5(ex_funct7b5), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .ex_memwrite(ex_memwrite), .ex_illegal(ex_illegal)
    );

    // Register file beside the stage: combinational read, write at the edge.
    logic [31:0] regs [32];
    assign rf_data1 = regs[if_instr[19:15]];
    assign rf_data2 = regs[if_instr[24:20]];

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) regs[i] <= 32'h1000_0000 + 32'(i);
        end else if (wb_regwrite && (wb_rd != 5'd0)) begin
            regs[wb_rd] <= wb_data;
        end
    end

    // ------------------------------------------------------------- checking
    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------ reference model
    typedef struct packed {
        logic        valid;
        logic [31:0] pc, op1, op2, imm;
        logic [4:0]  rd;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic        f7b5, regwrite, memread, memwrite, illegal;
    } idex_t;

    idex_t mdl;

    function automatic logic [31:0] ref_imm(input logic [31:0] s);
        int v;
        v = $signed(s);
        case (s[6:0])
            OPC_OP_IMM, OPC_LOAD, OPC_JALR: return 32'(v >>> 20);
            OPC_STORE:  return 32'(((v >>> 25) << 5) | int'(s[11:7]));
            OPC_BRANCH: return 32'(((v >>> 31) << 12) | (int'(s[7]) << 11) |
                                   (int'(s[30:25]) << 5) | (int'(s[11:8]) << 1));
            OPC_LUI, OPC_AUIPC: return s & 32'hFFFF_F000;
            OPC_JAL:    return 32'(((v >>> 31) << 20) | (int'(s[19:12]) << 12) |
                                   (int'(s[20]) << 11) | (int'(s[30:21]) << 1));
            default:    return 32'h0;
        endcase
    endfunction

    // Value an operand should carry given the current pipeline inputs.
    function automatic logic [31:0] ref_operand(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (FWD && exmem_regwrite && !exmem_memread && exmem_rd == a) return exmem_data;
        if (wb_regwrite && wb_rd == a) return wb_data;
        return regs[a];
    endfunction

    function automatic idex_t ref_decode(input logic [31:0] i, input logic [31:0] pc);
        idex_t e;
        logic [6:0] o;
        o          = i[6:0];
        e.valid    = 1'b1;
        e.pc       = pc;
        e.op1      = ref_operand(i[19:15]);
        e.op2      = ref_operand(i[24:20]);
        e.imm      = ref_imm(i);
        e.rd       = i[11:7];
        e.opcode   = o;
        e.funct3   = i[14:12];
        e.f7b5     = i[30];
        e.regwrite = o inside {OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC};
        e.memread  = (o == OPC_LOAD);
        e.memwrite = (o == OPC_STORE);
        e.illegal  = !(o inside {OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH,
                                 OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC});
        return e;
    endfunction

    task automatic check_idex(input string tag, input idex_t e);
        check({tag, ".valid"},    32'(ex_valid),    32'(e.valid));
        check({tag, ".pc"},       ex_pc,            e.pc);
        check({tag, ".op1"},      ex_op1,           e.op1);
        check({tag, ".op2"},      ex_op2,           e.op2);
        check({tag, ".imm"},      ex_imm,           e.imm);
        check({tag, ".rd"},       32'(ex_rd),       32'(e.rd));
        check({tag, ".opcode"},   32'(ex_opcode),   32'(e.opcode));
        check({tag, ".funct3"},   32'(ex_funct3),   32'(e.funct3));
        check({tag, ".f7b5"},     32'(ex_funct7b5), 32'(e.f7b5));
        check({tag, ".regwrite"}, 32'(ex_regwrite), 32'(e.regwrite));
        check({tag, ".memread"},  32'(ex_memread),  32'(e.memread));
        check({tag, ".memwrite"}, 32'(ex_memwrite), 32'(e.memwrite));
        check({tag, ".illegal"},  32'(ex_illegal),  32'(e.illegal));
    endtask

    // One modelled cycle: predict readiness and the next ID/EX contents from
    // the hazard, stall and flush rules, then compare after the edge.
    task automatic step(input string tag);
        logic [6:0] o;
        logic [4:0] a1, a2;
        logic       u1, u2, dep, exp_ready;
        idex_t      nxt;
        #1;
        o   = if_instr[6:0];
        a1  = if_instr[19:15];
        a2  = if_instr[24:20];
        u1  = !(o inside {OPC_LUI, OPC_AUIPC, OPC_JAL}) && a1 != 5'd0;
        u2  = (o inside {OPC_OP, OPC_STORE, OPC_BRANCH}) && a2 != 5'd0;
        dep = mdl.valid && mdl.regwrite && ((u1 && mdl.rd == a1) || (u2 && mdl.rd == a2));
        if (exmem_regwrite && ((u1 && exmem_rd == a1) || (u2 && exmem_rd == a2)) &&
            (exmem_memread || !FWD))
            dep = 1'b1;
        dep       = dep && if_valid;
        exp_ready = flush || !(ex_stall || dep);
        check({tag, ".id_ready"}, 32'(id_ready), 32'(exp_ready));
        check({tag, ".rf_read1"}, 32'(rf_read1), 32'(a1));
        check({tag, ".rf_read2"}, 32'(rf_read2), 32'(a2));
        nxt = mdl;
        if (flush)          nxt = '0;
        else if (!ex_stall) nxt = (if_valid && !dep) ? ref_decode(if_instr, if_pc) : '0;
        @(posedge clock); #1;
        mdl = nxt;
        check_idex(tag, mdl);
    endtask

    // -------------------------------------------------------------- helpers
    task automatic tick();
        @(posedge clock); #1;
    endtask

    task automatic idle();
        if_valid = 1'b0; if_instr = 32'h0000_0013; if_pc = 32'h0;
        exmem_regwrite = 1'b0; exmem_memread = 1'b0; exmem_rd = 5'd0; exmem_data = 32'h0;
        wb_regwrite = 1'b0; wb_rd = 5'd0; wb_data = 32'h0;
        ex_stall = 1'b0; flush = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        mdl = '0;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0]  opcs [10];
        logic [31:0] r;
        opcs = '{OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH,
                 OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC, 7'b1110011};
        r        = $urandom;
        r[6:0]   = opcs[$urandom_range(0, 9)];
        r[11:7]  = 5'($urandom_range(0, 7));
        r[19:15] = 5'($urandom_range(0, 7));
        r[24:20] = 5'($urandom_range(0, 7));
        return r;
    endfunction

    // Producer followed by a dependent consumer. The producer walks
    // ID/EX -> EX/MEM -> WB one stage per cycle; count the bubbles before the
    // consumer is accepted and check the operand it finally carries.
    task automatic raw_pair(input string tag, input logic [31:0] prod, input logic [31:0] cons,
                            input logic is_load, input int exp_bubbles);
        int          bubbles;
        bit          done;
        logic [31:0] val;
        logic [4:0]  prd;
        val = $urandom;
        prd = prod[11:7];
        idle();
        if_valid = 1'b1; if_instr = prod; if_pc = 32'h200;
        #1 check({tag, ".prod_ready"}, 32'(id_ready), 32'd1);
        tick();
        if_instr = cons; if_pc = 32'h204;
        bubbles = 0;
        done    = 1'b0;
        for (int age = 0; age < 6 && !done; age++) begin
            exmem_regwrite = (age == 1);
            exmem_memread  = (age == 1) && is_load;
            exmem_rd       = prd;
            // A load's EX/MEM value is its address, never the loaded data.
            exmem_data     = is_load ? ~val : val;
            wb_regwrite    = (age == 2);
            wb_rd          = prd;
            wb_data        = val;
            #1;
            if (id_ready) done = 1'b1;
            else          bubbles++;
            tick();
            if (!done) check({tag, ".bubble_valid"}, 32'(ex_valid), 32'd0);
        end
        check({tag, ".accepted"}, 32'(done), 32'd1);
        check({tag, ".bubbles"},  32'(bubbles), 32'(exp_bubbles));
        check({tag, ".valid"},    32'(ex_valid), 32'd1);
        check({tag, ".op1"},      ex_op1, val);
        check({tag, ".op2"},      ex_op2, val);
        check({tag, ".rd"},       32'(ex_rd), 32'(cons[11:7]));
        idle();
    endtask

    // ----------------------------------------------------------------- main
    initial begin
        mdl = '0;
        do_reset();

        // Reset state.
        check("rst.id_ready", 32'(id_ready), 32'd1);
        check("rst.valid",    32'(ex_valid), 32'd0);
        check("rst.pc",       ex_pc, 32'h0);
        check("rst.regwrite", 32'(ex_regwrite), 32'd0);
        check("rst.imm",      ex_imm, 32'h0);

        // addi x1,x0,5
        if_valid = 1'b1; if_instr = {12'd5, 5'd0, 3'b000, 5'd1, OPC_OP_IMM}; if_pc = 32'h100;
        #1;
        check("addi.id_ready", 32'(id_ready), 32'd1);
        check("addi.rf_read1", 32'(rf_read1), 32'd0);
        tick();
        check("addi.valid",    32'(ex_valid), 32'd1);
        check("addi.imm",      ex_imm, 32'd5);
        check("addi.op1",      ex_op1, 32'd0);
        check("addi.rd",       32'(ex_rd), 32'd1);
        check("addi.regwrite", 32'(ex_regwrite), 32'd1);
        check("addi.pc",       ex_pc, 32'h100);

        // WB writes x3 while add x4,x3,x3 is decoded.
        if_instr = {7'b0, 5'd3, 5'd3, 3'b000, 5'd4, OPC_OP}; if_pc = 32'h104;
        wb_regwrite = 1'b1; wb_rd = 5'd3; wb_data = 32'h0000_DEAD;
        tick();
        check("wbbyp.op1", ex_op1, 32'h0000_DEAD);
        check("wbbyp.op2", ex_op2, 32'h0000_DEAD);
        idle();

        // lw x2,0(x1) ; add x5,x2,x2
        raw_pair("loaduse", {12'd0, 5'd1, 3'b010, 5'd2, OPC_LOAD},
                 {7'b0, 5'd2, 5'd2, 3'b000, 5'd5, OPC_OP}, 1'b1, 2);
        // add x6,x1,x2 ; sub x7,x6,x6
        raw_pair("aluraw", {7'b0, 5'd2, 5'd1, 3'b000, 5'd6, OPC_OP},
                 {7'b0100000, 5'd6, 5'd6, 3'b000, 5'd7, OPC_OP}, 1'b0, FWD ? 1 : 2);

        // flush together with ex_stall while ID/EX holds a valid instruction.
        if_valid = 1'b1; if_instr = {12'h7FF, 5'd0, 3'b000, 5'd8, OPC_OP_IMM}; if_pc = 32'h300;
        flush = 1'b1; ex_stall = 1'b1;
        #1 check("flush.id_ready", 32'(id_ready), 32'd1);
        tick();
        check("flush.valid",    32'(ex_valid), 32'd0);
        check("flush.regwrite", 32'(ex_regwrite), 32'd0);
        idle();

        // Reset in the middle of a stall.
        if_valid = 1'b1; if_instr = {12'd3, 5'd0, 3'b000, 5'd1, OPC_OP_IMM}; if_pc = 32'h400;
        tick();
        ex_stall = 1'b1; if_instr = {7'b0, 5'd1, 5'd1, 3'b000, 5'd2, OPC_OP};
        #1 check("stall.id_ready", 32'(id_ready), 32'd0);
        tick();
        check("stall.hold_valid", 32'(ex_valid), 32'd1);
        check("stall.hold_pc",    ex_pc, 32'h400);
        #2 reset_n = 1'b0;
        #1;
        check("arst.valid",    32'(ex_valid), 32'd0);
        check("arst.pc",       ex_pc, 32'h0);
        check("arst.imm",      ex_imm, 32'h0);
        check("arst.rd",       32'(ex_rd), 32'd0);
        check("arst.regwrite", 32'(ex_regwrite), 32'd0);
        idle();
        reset_n = 1'b1;
        if_valid = 1'b1; if_instr = {12'hFFF, 5'd0, 3'b000, 5'd9, OPC_OP_IMM}; if_pc = 32'h500;
        tick();
        check("post_rst.valid", 32'(ex_valid), 32'd1);
        check("post_rst.imm",   ex_imm, 32'hFFFF_FFFF);
        check("post_rst.rd",    32'(ex_rd), 32'd9);
        check("post_rst.pc",    ex_pc, 32'h500);

        // Randomized traffic against the model.
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            if_valid       = ($urandom_range(0, 7) != 0);
            if_instr       = rand_instr();
            if_pc          = $urandom & 32'hFFFF_FFFC;
            exmem_regwrite = $urandom_range(0, 1) == 1;
            exmem_memread  = ($urandom_range(0, 3) == 0);
            exmem_rd       = 5'($urandom_range(0, 7));
            exmem_data     = $urandom;
            wb_regwrite    = $urandom_range(0, 1) == 1;
            wb_rd          = 5'($urandom_range(0, 7));
            wb_data        = $urandom;
            ex_stall       = ($urandom_range(0, 7) == 0);
            flush          = ($urandom_range(0, 15) == 0);
            step($sformatf("rnd%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
